// File: rtl/exec_pkg.sv
// Types and constants shared between the execute stage and the writeback/EFLAGS commit logic.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_OR  = 3'd1,
    OP_NOT = 3'd2,
    OP_DAA = 3'd3,
    OP_AND = 3'd4,
    OP_CLD = 3'd5,
    OP_SUB = 3'd6,
    OP_STD = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } fifo_cnt_e;

  localparam int OF_BIT = 11;
  localparam int DF_BIT = 10;
  localparam int SF_BIT = 7;
  localparam int ZF_BIT = 6;
  localparam int AF_BIT = 4;
  localparam int PF_BIT = 2;
  localparam int CF_BIT = 0;

  localparam logic [31:0] EFLAGS_RST   = 32'h0000_0002;
  localparam logic [31:0] EFLAGS_WMASK = 32'h0000_0CD5;
  localparam logic [31:0] EFLAGS_FIXED = 32'h0000_0002;

  localparam logic [31:0] MASK_ARITH = (32'h1 << OF_BIT) | (32'h1 << SF_BIT) | (32'h1 << ZF_BIT)
                                     | (32'h1 << AF_BIT) | (32'h1 << PF_BIT) | (32'h1 << CF_BIT);
  localparam logic [31:0] MASK_LOGIC = MASK_ARITH & ~(32'h1 << AF_BIT);
  localparam logic [31:0] MASK_DAA   = MASK_ARITH & ~(32'h1 << OF_BIT);
  localparam logic [31:0] MASK_DF    = 32'h1 << DF_BIT;

  function automatic logic [31:0] upd_mask(alu_op_e op);
    logic [31:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: m = MASK_ARITH;
      OP_OR,  OP_AND: m = MASK_LOGIC;
      OP_DAA:         m = MASK_DAA;
      OP_CLD, OP_STD: m = MASK_DF;
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer with registered head output; occupancy kept as a small FSM.
module skid_fifo2
  import exec_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  fifo_cnt_e   state_q, state_d;
  logic        head_q, tail_q;
  logic [W-1:0] mem_q [2];
  logic        push, pop;

  assign in_ready_o  = (state_q != CNT_TWO);
  assign out_valid_o = (state_q != CNT_EMPTY);
  assign out_data_o  = mem_q[head_q];
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= CNT_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_EMPTY: if (push) state_d = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)      state_d = CNT_TWO;
        else if (pop && !push) state_d = CNT_EMPTY;
      end
      CNT_TWO:   if (pop) state_d = CNT_ONE;
      default:   state_d = CNT_EMPTY;
    endcase
    if (flush_i) state_d = CNT_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else if (flush_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/wb_eflags_commit.sv
// Buffers ALU results toward writeback and owns architectural EFLAGS, merging each
// accepted op's flags under its update mask and feeding the result back to the ALU.
module wb_eflags_commit #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] EFLAGS_RST = exec_pkg::EFLAGS_RST
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_flags,
  input  logic [2:0]  ex_dest,
  input  logic        ex_wr_en,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_alu_out,
  output logic [2:0]  wb_dest,
  output logic        wb_wr_en,
  output logic [31:0] eflags,
  input  logic        eflags_ld,
  input  logic [31:0] eflags_ld_val,
  input  logic        flush
);
  import exec_pkg::*;

  if (DEPTH != 2) begin : g_depth_check
    $error("wb_eflags_commit supports DEPTH == 2 only");
  end

  localparam int FW = 32 + 3 + 1;

  logic          fifo_in_ready;
  logic          accept;
  logic [FW-1:0] fifo_out;
  logic [31:0]   eflags_q, eflags_d;
  logic [31:0]   mask;

  // Ready never looks at ex_valid, so execute can compute valid from ready freely.
  assign ex_ready = fifo_in_ready && !eflags_ld && !flush;
  assign accept   = ex_valid && ex_ready;

  skid_fifo2 #(.W(FW)) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (flush),
    .in_valid_i  (accept),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   ({ex_alu_out, ex_dest, ex_wr_en}),
    .out_valid_o (wb_valid),
    .out_ready_i (wb_ready),
    .out_data_o  (fifo_out)
  );

  assign {wb_alu_out, wb_dest, wb_wr_en} = fifo_out;

  assign mask = upd_mask(alu_op_e'(ex_op));

  always_comb begin
    eflags_d = eflags_q;
    if (eflags_ld)
      eflags_d = (eflags_ld_val & EFLAGS_WMASK) | EFLAGS_FIXED;
    else if (accept)
      eflags_d = (((eflags_q & ~mask) | (ex_flags & mask)) & EFLAGS_WMASK) | EFLAGS_FIXED;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) eflags_q <= EFLAGS_RST;
    else     eflags_q <= eflags_d;
  end

  assign eflags = eflags_q;

endmodule

// File: tb/tb_wb_eflags_commit.sv
// Directed bench: table of flag-merge vectors plus hand sequences for FIFO, flush and reset corners.
module tb_wb_eflags_commit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_op;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_flags;
  logic [2:0]  ex_dest;
  logic        ex_wr_en;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_alu_out;
  logic [2:0]  wb_dest;
  logic        wb_wr_en;
  logic [31:0] eflags;
  logic        eflags_ld;
  logic [31:0] eflags_ld_val;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  wb_eflags_commit dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_alu_out(ex_alu_out), .ex_flags(ex_flags), .ex_dest(ex_dest), .ex_wr_en(ex_wr_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_alu_out(wb_alu_out),
    .wb_dest(wb_dest), .wb_wr_en(wb_wr_en),
    .eflags(eflags), .eflags_ld(eflags_ld), .eflags_ld_val(eflags_ld_val), .flush(flush)
  );

  typedef struct {
    logic        ld;
    logic [31:0] ld_val;
    logic [2:0]  op;
    logic [31:0] flags;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] alu,
                       input logic [31:0] fl, input logic [2:0] dst, input logic we);
    ex_valid   = v;
    ex_op      = op;
    ex_alu_out = alu;
    ex_flags   = fl;
    ex_dest    = dst;
    ex_wr_en   = we;
  endtask

  initial begin
    logic [31:0] prev;

    // ld, ld_val, op, flags, expected eflags after the edge
    vt[0]  = '{1'b0, 32'h0,         3'd0, 32'h0000_0ED5, 32'h0000_08D7}; // ADD
    vt[1]  = '{1'b1, 32'h0000_0013, 3'd0, 32'hFFFF_FFFF, 32'h0000_0013}; // load, ADD blocked
    vt[2]  = '{1'b0, 32'h0,         3'd1, 32'h0000_0000, 32'h0000_0012}; // OR keeps AF
    vt[3]  = '{1'b0, 32'h0,         3'd7, 32'h0000_0400, 32'h0000_0412}; // STD
    vt[4]  = '{1'b0, 32'h0,         3'd5, 32'h0000_0000, 32'h0000_0012}; // CLD
    vt[5]  = '{1'b0, 32'h0,         3'd2, 32'hFFFF_FFFF, 32'h0000_0012}; // NOT touches nothing
    vt[6]  = '{1'b0, 32'h0,         3'd3, 32'hFFFF_FFFF, 32'h0000_00D7}; // DAA keeps OF
    vt[7]  = '{1'b0, 32'h0,         3'd6, 32'h0000_0000, 32'h0000_0002}; // SUB
    vt[8]  = '{1'b0, 32'h0,         3'd4, 32'hFFFF_FFFF, 32'h0000_08C7}; // AND
    vt[9]  = '{1'b1, 32'hFFFF_FFFF, 3'd0, 32'h0000_0000, 32'h0000_0CD7}; // load all ones
    vt[10] = '{1'b0, 32'h0,         3'd0, 32'h0000_0400, 32'h0000_0402}; // ADD leaves DF alone

    RST = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    wb_ready = 1'b0; eflags_ld = 1'b0; eflags_ld_val = '0; flush = 1'b0;
    #2;
    chk("rst_eflags",   eflags,     32'h0000_0002);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_wb_alu",   wb_alu_out, 32'h0);
    chk("rst_wb_dest",  {29'b0, wb_dest},  32'h0);
    chk("rst_wb_wr",    {31'b0, wb_wr_en}, 32'h0);
    #6 RST = 1'b0;
    #1 chk("rst_ready", {31'b0, ex_ready}, 32'h1);
    step();

    // Table: flag merges with writeback always ready.
    wb_ready = 1'b1;
    prev = 32'h0000_0002;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].op, 32'h100 + i, vt[i].flags, i[2:0], 1'b1);
      eflags_ld = vt[i].ld; eflags_ld_val = vt[i].ld_val;
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, ex_ready}, {31'b0, !vt[i].ld});
      chk($sformatf("v%0d_noforward", i), eflags, prev);
      step();
      chk($sformatf("v%0d_eflags", i), eflags, vt[i].exp);
      chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, !vt[i].ld});
      if (!vt[i].ld) chk($sformatf("v%0d_wb_alu", i), wb_alu_out, 32'h100 + i);
      prev = vt[i].exp;
    end
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    eflags_ld = 1'b0;
    step();
    chk("tbl_drained", {31'b0, wb_valid}, 32'h0);

    // Backpressure: two fill, third stalls, then drain in order.
    wb_ready = 1'b0;
    drive(1'b1, 3'd2, 32'hA1, 32'h0, 3'd1, 1'b1);
    #1 chk("bp_rdy0", {31'b0, ex_ready}, 32'h1);
    step();
    drive(1'b1, 3'd2, 32'hB2, 32'h0, 3'd2, 1'b0);
    #1 chk("bp_rdy1", {31'b0, ex_ready}, 32'h1);
    step();
    drive(1'b1, 3'd2, 32'hC3, 32'h0, 3'd3, 1'b1);
    #1 chk("bp_full", {31'b0, ex_ready}, 32'h0);
    chk("bp_head_a", wb_alu_out, 32'hA1);
    chk("bp_dest_a", {29'b0, wb_dest}, 32'h1);
    step();
    chk("bp_hold_a", wb_alu_out, 32'hA1);
    chk("bp_hold_v", {31'b0, wb_valid}, 32'h1);
    wb_ready = 1'b1;
    #1 chk("bp_full2", {31'b0, ex_ready}, 32'h0);
    step();
    chk("bp_head_b", wb_alu_out, 32'hB2);
    chk("bp_wr_b",   {31'b0, wb_wr_en}, 32'h0);
    chk("bp_rdy_c",  {31'b0, ex_ready}, 32'h1);
    step();
    chk("bp_head_c", wb_alu_out, 32'hC3);
    chk("bp_dest_c", {29'b0, wb_dest}, 32'h3);
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    chk("bp_empty", {31'b0, wb_valid}, 32'h0);

    // Push and pop together at one entry.
    wb_ready = 1'b0;
    drive(1'b1, 3'd2, 32'hD4, 32'h0, 3'd4, 1'b1);
    step();
    drive(1'b1, 3'd2, 32'hE5, 32'h0, 3'd5, 1'b1);
    wb_ready = 1'b1;
    #1 chk("pp_rdy", {31'b0, ex_ready}, 32'h1);
    chk("pp_head_d", wb_alu_out, 32'hD4);
    step();
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    wb_ready = 1'b0;
    step();
    chk("pp_head_e", wb_alu_out, 32'hE5);
    chk("pp_one_v",  {31'b0, wb_valid}, 32'h1);
    chk("pp_one_rdy", {31'b0, ex_ready}, 32'h1);
    wb_ready = 1'b1;
    step();
    chk("pp_empty", {31'b0, wb_valid}, 32'h0);

    // Flush with two entries held; EFLAGS must not revert.
    wb_ready = 1'b0;
    drive(1'b1, 3'd2, 32'h51, 32'h0, 3'd1, 1'b1);
    step(); step();
    chk("fl_full", {31'b0, ex_ready}, 32'h0);
    drive(1'b1, 3'd0, 32'h52, 32'hFFF, 3'd2, 1'b1);
    flush = 1'b1;
    #1 chk("fl_rdy", {31'b0, ex_ready}, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    chk("fl_valid",  {31'b0, wb_valid}, 32'h0);
    chk("fl_eflags", eflags, 32'h0000_0402);
    #1 chk("fl_rdy_after", {31'b0, ex_ready}, 32'h1);

    // Flush and load in the same cycle.
    drive(1'b1, 3'd2, 32'h61, 32'h0, 3'd1, 1'b1);
    step();
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    flush = 1'b1; eflags_ld = 1'b1; eflags_ld_val = 32'h0000_0001;
    step();
    flush = 1'b0; eflags_ld = 1'b0;
    chk("flld_valid",  {31'b0, wb_valid}, 32'h0);
    chk("flld_eflags", eflags, 32'h0000_0003);

    // Reset asserted mid-drain.
    drive(1'b1, 3'd2, 32'h11, 32'h0, 3'd5, 1'b1);
    step();
    drive(1'b1, 3'd2, 32'h22, 32'h0, 3'd5, 1'b1);
    step();
    drive(1'b0, 3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
    wb_ready = 1'b1;
    step();
    chk("rd_mid_valid", {31'b0, wb_valid}, 32'h1);
    chk("rd_mid_head",  wb_alu_out, 32'h22);
    RST = 1'b1;
    #1;
    chk("rd_valid",  {31'b0, wb_valid}, 32'h0);
    chk("rd_alu",    wb_alu_out, 32'h0);
    chk("rd_dest",   {29'b0, wb_dest},  32'h0);
    chk("rd_wr",     {31'b0, wb_wr_en}, 32'h0);
    chk("rd_eflags", eflags, 32'h0000_0002);
    RST = 1'b0;
    #1 chk("rd_ready", {31'b0, ex_ready}, 32'h1);
    step();
    chk("rd_after_valid", {31'b0, wb_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
